// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, the halt word and the fetch sequencer state type.
package cpu_pkg;

  localparam logic [3:0]  OP_LOAD   = 4'b0000;
  localparam logic [3:0]  OP_SUBI   = 4'b1001;
  localparam logic [3:0]  OP_JMP    = 4'b0101;
  localparam logic [3:0]  OP_BRNE   = 4'b1000;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    ISSUE,
    HALT
  } fetch_state_e;

  // LOAD and SUBI are followed in program memory by a data word.
  function automatic logic has_data_word(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetches one- and two-word instructions from program memory and issues them to execute.
// Optional feature: define FETCH_SEQ_PERF_EN to add the saturating retired_cnt output.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [INSTR_W-1:0] pmem_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [INSTR_W-1:0] ex_instr,
  output logic [INSTR_W-1:0] ex_imm,
  output logic               ex_two_word,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ex_instr_q, ex_imm_q;
  logic               ex_valid_q, ex_two_word_q, halted_q;

  logic [3:0]         fetch_op, issue_op;
  logic [ADDR_W-1:0]  branch_target;
  logic               handshake, take_branch;

  assign fetch_op      = pmem_data[15:12];
  assign issue_op      = ex_instr_q[15:12];
  assign branch_target = ADDR_W'(ex_instr_q[11:7]);
  assign handshake     = (state_q == ISSUE) && ex_valid_q && ex_ready;
  assign take_branch   = (issue_op == OP_JMP) || ((issue_op == OP_BRNE) && !zero_flag);

  // The pc also addresses the trailing data word, so memory always sees pc.
  assign pmem_addr   = pc_q;
  assign pc          = pc_q;
  assign ex_valid    = ex_valid_q;
  assign ex_instr    = ex_instr_q;
  assign ex_imm      = ex_imm_q;
  assign ex_two_word = ex_two_word_q;
  assign halted      = halted_q;

  always_comb begin
    pc_d = pc_q;
    case (state_q)
      FETCH, FETCH_IMM: pc_d = pc_q + ADDR_W'(1);
      ISSUE:            if (handshake && take_branch) pc_d = branch_target;
      default:          pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      ex_valid_q    <= 1'b0;
      ex_instr_q    <= '0;
      ex_imm_q      <= '0;
      ex_two_word_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (run) state_q <= FETCH;
        end
        FETCH: begin
          ex_instr_q    <= pmem_data;
          ex_imm_q      <= '0;
          ex_two_word_q <= 1'b0;
          if (pmem_data == INSTR_W'(HALT_WORD)) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (has_data_word(fetch_op)) begin
            state_q       <= FETCH_IMM;
            ex_two_word_q <= 1'b1;
          end else begin
            state_q    <= ISSUE;
            ex_valid_q <= 1'b1;
          end
        end
        FETCH_IMM: begin
          ex_imm_q   <= pmem_data;
          ex_valid_q <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          if (handshake) begin
            ex_valid_q <= 1'b0;
            state_q    <= run ? FETCH : IDLE;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (handshake && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule
